mul_seq_ctrl: RTL and testbench
===============================

Name: mul_seq_ctrl

Overview:
- Sequencer that drives the shared 3-product 16x16 multiplier cell. The cell takes src1/src2 and produces p1=lo*lo, p2=a_lo*b_hi and p3=a_hi*b_lo, registered one clock when enabled.
- Accepts one 32x32 multiply request at a time over a valid/ready handshake.
- Issues one cell pass for a 32-bit low result, or two passes for a high result (pass 2 reuses the p1 product as hi*hi).
- Combines the partial products, applies the signed correction, and returns the result over a valid/ready response channel.
- Sits between the CPU execute stage and the multiplier cell.

Parameters:
SUPPORT_MULX, 1, 1 = ops 1..3 computed; 0 = ops 1..3 complete on the MUL timeline with rsp_data=0 and rsp_illegal=1.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept (IDLE only)
req_op  in  2  0=MUL (low 32), 1=MULXUU, 2=MULXSU (a signed, b unsigned), 3=MULXSS (high 32)
req_a  in  32  operand a
req_b  in  32  operand b
cell_src1  out  32  to cell E_src1
cell_src2  out  32  to cell E_src2
cell_en  out  1  to cell M_en (load enable)
cell_p1  in  32  cell lo*lo product (hi*hi on pass 2)
cell_p2  in  32  cell a_lo*b_hi product
cell_p3  in  32  cell a_hi*b_lo product
rsp_valid  out  1  result present
rsp_ready  in  1  consumer accepts
rsp_data  out  32  result
rsp_illegal  out  1  op unsupported (SUPPORT_MULX=0)
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE; rsp_valid=0, rsp_data=0, rsp_illegal=0, cell_en=0, cell_src1=0, cell_src2=0, busy=0; all captured registers cleared.
- Reset mid-operation: the in-flight op is discarded with no response and the block returns to IDLE the next cycle.
- States: IDLE, ISSUE1, CAP1, CAP2, COMBINE, RESP.
- IDLE: req_ready=1. When req_valid=1, latch op/a/b and go to ISSUE1. Nothing is accepted in any other state.
- ISSUE1: cell_src1=a, cell_src2=b, cell_en=1. Next state is CAP1.
- CAP1: register lo = p1 + ((p2+p3)<<16) over a 64-bit sum, and keep the 33-bit mid = p2+p3 plus the p1 carry chain.
  - Op MUL, or SUPPORT_MULX=0: load rsp_data=lo[31:0] and go to RESP.
  - High ops: in the same cycle drive cell_src1={16'h0,a[31:16]}, cell_src2={16'h0,b[31:16]}, cell_en=1, then go to CAP2.
- CAP2: capture p4=cell_p1, then go to COMBINE.
- COMBINE: compute the unsigned high word uhi = (p4<<32 + (mid<<16) + p1)[63:32], then apply the signed correction (all mod 2^32):
  - MULXUU: rsp_data = uhi.
  - MULXSU: rsp_data = uhi - (a[31] ? b : 0).
  - MULXSS: rsp_data = uhi - (a[31] ? b : 0) - (b[31] ? a : 0).
  - Register the result and go to RESP.
- RESP: rsp_valid=1; rsp_data and rsp_illegal are held stable. On rsp_ready=1, clear rsp_valid and go to IDLE. Backpressure is unbounded.
- cell_en is 1 only in ISSUE1, and in CAP1 for high ops, so the cell outputs hold at all other times. cell_src holds its last value when cell_en=0.
- Latency from the accept edge to rsp_valid:
  - MUL: 3 cycles (ISSUE1, CAP1, RESP).
  - High ops: 5 cycles.
- Throughput:
  - MUL: one request per 4 cycles.
  - High ops: one request per 6 cycles, when rsp_ready is held at 1.
- Simultaneous events:
  - RESP with rsp_ready=1 and req_valid=1 in the same cycle: the request is not accepted until the following IDLE cycle.
  - req inputs are ignored outside IDLE.

Decomposition:
- Package mul_seq_pkg holds:
  - the op encodings MUL_OP_LO, MULXUU, MULXSU, MULXSS;
  - the state enum;
  - the cell product width constant (32) and half width (16).
- One sub-module, mul_seq_combine: purely combinational. Takes p1/p2/p3/p4, a, b and op, and produces lo32 and hi32 with the sign correction. It is unit-testable on its own.

Test Plan:
- MUL a=0x00010002, b=0x00030004 -> rsp_data=0x000A0008, rsp_valid exactly 3 cycles after accept, cell_en high for 1 cycle.
- MULXUU a=b=0xFFFFFFFF -> rsp_data=0xFFFFFFFE at +5 cycles, cell_en high for 2 consecutive cycles, second pass with src=0x0000FFFF. MUL on the same operands -> 0x00000001.
- MULXSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF. MULXSS on the same operands -> 0x00000000. MULXSS a=0x80000000, b=0x00000002 -> 0xFFFFFFFF.
- Backpressure: hold rsp_ready=0 for 10 cycles with req_valid=1 -> rsp_data stable, req_ready=0 and busy=1 throughout, next request accepted only in the cycle after the rsp handshake.
- Reset asserted in CAP2 -> next cycle state=IDLE, rsp_valid=0, cell_en=0, no response ever issued; a fresh MUL then completes correctly.
- SUPPORT_MULX=0: op=1, a=b=5 -> rsp_illegal=1, rsp_data=0 at +3 cycles. op=0 with the same operands -> 25, rsp_illegal=0.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared encodings and constants for the multiplier-cell sequencer.
package mul_seq_pkg;

  localparam int PROD_W = 32;
  localparam int HALF_W = 16;

  localparam logic [1:0] MUL_OP_LO = 2'd0;
  localparam logic [1:0] MULXUU    = 2'd1;
  localparam logic [1:0] MULXSU    = 2'd2;
  localparam logic [1:0] MULXSS    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE1,
    ST_CAP1,
    ST_CAP2,
    ST_COMBINE,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mul_seq_combine.sv
// Combines the cell partial products into the low word and the sign-corrected high word.
module mul_seq_combine
  import mul_seq_pkg::*;
(
  input  logic [PROD_W-1:0] p1_i,
  input  logic [PROD_W-1:0] p2_i,
  input  logic [PROD_W-1:0] p3_i,
  input  logic [PROD_W-1:0] p4_i,
  input  logic [PROD_W-1:0] a_i,
  input  logic [PROD_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [PROD_W-1:0] lo32_o,
  output logic [PROD_W-1:0] hi32_o
);

  logic [PROD_W:0]   mid;
  logic [PROD_W:0]   lo_ext;
  logic [PROD_W-1:0] uhi;
  logic [PROD_W-1:0] corr_a;
  logic [PROD_W-1:0] corr_b;

  assign mid    = {1'b0, p2_i} + {1'b0, p3_i};
  // The carry out of the low word links the two halves of the 64-bit sum.
  assign lo_ext = {1'b0, p1_i} + {1'b0, mid[HALF_W-1:0], {HALF_W{1'b0}}};
  assign lo32_o = lo_ext[PROD_W-1:0];
  assign uhi    = p4_i + {{(HALF_W-1){1'b0}}, mid[PROD_W:HALF_W]}
                + {{(PROD_W-1){1'b0}}, lo_ext[PROD_W]};

  assign corr_a = (((op_i == MULXSU) || (op_i == MULXSS)) && a_i[PROD_W-1]) ? b_i : '0;
  assign corr_b = ((op_i == MULXSS) && b_i[PROD_W-1]) ? a_i : '0;
  assign hi32_o = uhi - corr_a - corr_b;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequences 32x32 multiplies through the shared 3-product 16x16 cell:
// one pass for the low word, two passes (hi*hi on pass 2) for the high word.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter bit SUPPORT_MULX = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [PROD_W-1:0] req_a,
  input  logic [PROD_W-1:0] req_b,
  output logic [PROD_W-1:0] cell_src1,
  output logic [PROD_W-1:0] cell_src2,
  output logic              cell_en,
  input  logic [PROD_W-1:0] cell_p1,
  input  logic [PROD_W-1:0] cell_p2,
  input  logic [PROD_W-1:0] cell_p3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_data,
  output logic              rsp_illegal,
  output logic              busy
);

  state_e            state_q;
  logic [1:0]        op_q;
  logic [PROD_W-1:0] a_q, b_q;
  logic [PROD_W-1:0] p1_q, p2_q, p3_q, p4_q;
  logic [PROD_W-1:0] rsp_data_q, cell_src1_q, cell_src2_q;
  logic              rsp_valid_q, rsp_illegal_q, cell_en_q;
  logic              high_op, illegal_op;
  logic [PROD_W-1:0] comb_p1_d, comb_p2_d, comb_p3_d;
  logic [PROD_W-1:0] lo32, hi32;

  assign high_op    = (op_q != MUL_OP_LO) && SUPPORT_MULX;
  assign illegal_op = (op_q != MUL_OP_LO) && !SUPPORT_MULX;

  // Pass-1 products are live only during CAP1; afterwards the cell holds pass 2.
  always_comb begin
    comb_p1_d = p1_q;
    comb_p2_d = p2_q;
    comb_p3_d = p3_q;
    if (state_q == ST_CAP1) begin
      comb_p1_d = cell_p1;
      comb_p2_d = cell_p2;
      comb_p3_d = cell_p3;
    end
  end

  mul_seq_combine u_combine (
    .p1_i   (comb_p1_d),
    .p2_i   (comb_p2_d),
    .p3_i   (comb_p3_d),
    .p4_i   (p4_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .op_i   (op_q),
    .lo32_o (lo32),
    .hi32_o (hi32)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      op_q          <= MUL_OP_LO;
      a_q           <= '0;
      b_q           <= '0;
      p1_q          <= '0;
      p2_q          <= '0;
      p3_q          <= '0;
      p4_q          <= '0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      cell_en_q     <= 1'b0;
      cell_src1_q   <= '0;
      cell_src2_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            a_q         <= req_a;
            b_q         <= req_b;
            cell_src1_q <= req_a;
            cell_src2_q <= req_b;
            cell_en_q   <= 1'b1;
            state_q     <= ST_ISSUE1;
          end
        end
        ST_ISSUE1: begin
          cell_en_q <= high_op;
          if (high_op) begin
            cell_src1_q <= {{HALF_W{1'b0}}, a_q[PROD_W-1:HALF_W]};
            cell_src2_q <= {{HALF_W{1'b0}}, b_q[PROD_W-1:HALF_W]};
          end
          state_q <= ST_CAP1;
        end
        ST_CAP1: begin
          p1_q      <= cell_p1;
          p2_q      <= cell_p2;
          p3_q      <= cell_p3;
          cell_en_q <= 1'b0;
          if (high_op) begin
            state_q <= ST_CAP2;
          end else begin
            rsp_data_q    <= illegal_op ? '0 : lo32;
            rsp_illegal_q <= illegal_op;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_CAP2: begin
          p4_q    <= cell_p1;
          state_q <= ST_COMBINE;
        end
        ST_COMBINE: begin
          rsp_data_q    <= hi32;
          rsp_illegal_q <= 1'b0;
          rsp_valid_q   <= 1'b1;
          state_q       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_illegal = rsp_illegal_q;
  assign cell_en     = cell_en_q;
  assign cell_src1   = cell_src1_q;
  assign cell_src2   = cell_src2_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench: instance 0 has SUPPORT_MULX=1, instance 1 has SUPPORT_MULX=0, each with a cell model.
module tb_mul_seq_ctrl;

  logic clk;
  logic reset;
  logic [1:0]       req_valid, req_ready, cell_en, rsp_valid, rsp_ready, rsp_illegal, busy;
  logic [1:0][1:0]  req_op;
  logic [1:0][31:0] req_a, req_b, cell_src1, cell_src2, cell_p1, cell_p2, cell_p3, rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          k;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        ill;
    int          lat;
    int          en;
  } vec_t;

  vec_t vecs[16];

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_dut
    mul_seq_ctrl #(.SUPPORT_MULX(gi == 0)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid[gi]),
      .req_ready   (req_ready[gi]),
      .req_op      (req_op[gi]),
      .req_a       (req_a[gi]),
      .req_b       (req_b[gi]),
      .cell_src1   (cell_src1[gi]),
      .cell_src2   (cell_src2[gi]),
      .cell_en     (cell_en[gi]),
      .cell_p1     (cell_p1[gi]),
      .cell_p2     (cell_p2[gi]),
      .cell_p3     (cell_p3[gi]),
      .rsp_valid   (rsp_valid[gi]),
      .rsp_ready   (rsp_ready[gi]),
      .rsp_data    (rsp_data[gi]),
      .rsp_illegal (rsp_illegal[gi]),
      .busy        (busy[gi])
    );
  end

  // Cell model: three 16x16 products, registered when enabled.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        cell_p1[k] <= '0;
        cell_p2[k] <= '0;
        cell_p3[k] <= '0;
      end else if (cell_en[k]) begin
        cell_p1[k] <= 32'(cell_src1[k][15:0])  * 32'(cell_src2[k][15:0]);
        cell_p2[k] <= 32'(cell_src1[k][15:0])  * 32'(cell_src2[k][31:16]);
        cell_p3[k] <= 32'(cell_src1[k][31:16]) * 32'(cell_src2[k][15:0]);
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int en_cnt;
    logic [31:0] s1, s2;
    cyc = 1;
    en_cnt = 0;
    s1 = '0;
    s2 = '0;
    check("req_ready_before", {31'h0, req_ready[v.k]}, 32'd1);
    rsp_ready[v.k] = 1'b1;
    req_valid[v.k] = 1'b1;
    req_op[v.k]    = v.op;
    req_a[v.k]     = v.a;
    req_b[v.k]     = v.b;
    step();
    req_valid[v.k] = 1'b0;
    while (!rsp_valid[v.k] && cyc < 20) begin
      if (cell_en[v.k]) begin
        en_cnt++;
        if (cyc == 2) begin
          s1 = cell_src1[v.k];
          s2 = cell_src2[v.k];
        end
      end
      step();
      cyc++;
    end
    check("latency", cyc, v.lat);
    check("rsp_data", rsp_data[v.k], v.data);
    check("rsp_illegal", {31'h0, rsp_illegal[v.k]}, {31'h0, v.ill});
    check("cell_en_cycles", en_cnt, v.en);
    if (v.en == 2) begin
      check("pass2_src1", s1, {16'h0, v.a[31:16]});
      check("pass2_src2", s2, {16'h0, v.b[31:16]});
    end
    $display("dut%0d op=%0d a=0x%08h b=0x%08h -> data=0x%08h ill=%0b lat=%0d",
             v.k, v.op, v.a, v.b, rsp_data[v.k], rsp_illegal[v.k], cyc);
    step();
    check("rsp_valid_after_hs", {31'h0, rsp_valid[v.k]}, 32'd0);
    check("req_ready_after_hs", {31'h0, req_ready[v.k]}, 32'd1);
  endtask

  initial begin
    int cyc;
    vecs[0]  = '{0, 2'd0, 32'h00010002, 32'h00030004, 32'h000A0008, 1'b0, 3, 1};
    vecs[1]  = '{0, 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 5, 2};
    vecs[2]  = '{0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 3, 1};
    vecs[3]  = '{0, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 2};
    vecs[4]  = '{0, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 5, 2};
    vecs[5]  = '{0, 2'd3, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 1'b0, 5, 2};
    vecs[6]  = '{0, 2'd1, 32'h80000000, 32'h00000004, 32'h00000002, 1'b0, 5, 2};
    vecs[7]  = '{0, 2'd2, 32'h80000000, 32'h00000004, 32'hFFFFFFFE, 1'b0, 5, 2};
    vecs[8]  = '{0, 2'd3, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 5, 2};
    vecs[9]  = '{0, 2'd1, 32'h00010000, 32'h00010000, 32'h00000001, 1'b0, 5, 2};
    vecs[10] = '{0, 2'd0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b0, 3, 1};
    vecs[11] = '{0, 2'd1, 32'h0000FFFF, 32'h0001FFFF, 32'h00000001, 1'b0, 5, 2};
    vecs[12] = '{0, 2'd0, 32'h0000FFFF, 32'h0001FFFF, 32'hFFFD0001, 1'b0, 3, 1};
    vecs[13] = '{0, 2'd2, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0, 5, 2};
    vecs[14] = '{1, 2'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 3, 1};
    vecs[15] = '{1, 2'd0, 32'h00000005, 32'h00000005, 32'h00000019, 1'b0, 3, 1};

    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b11;
    step();
    step();
    reset = 1'b0;

    check("reset_rsp_valid", {30'h0, rsp_valid}, 32'd0);
    check("reset_rsp_data", rsp_data[0], 32'd0);
    check("reset_rsp_illegal", {30'h0, rsp_illegal}, 32'd0);
    check("reset_cell_en", {30'h0, cell_en}, 32'd0);
    check("reset_cell_src1", cell_src1[0], 32'd0);
    check("reset_cell_src2", cell_src2[0], 32'd0);
    check("reset_busy", {30'h0, busy}, 32'd0);
    check("reset_req_ready", {30'h0, req_ready}, 32'd3);

    for (int i = 0; i < 16; i++) begin
      run_vec(vecs[i]);
    end

    // Backpressure: response held while a new request waits outside.
    rsp_ready[0] = 1'b0;
    req_valid[0] = 1'b1;
    req_op[0]    = 2'd0;
    req_a[0]     = 32'h00010002;
    req_b[0]     = 32'h00030004;
    step();
    req_a[0] = 32'd3;
    req_b[0] = 32'd7;
    cyc = 1;
    while (!rsp_valid[0] && cyc < 20) begin
      step();
      cyc++;
    end
    check("bp_latency", cyc, 3);
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_data", rsp_data[0], 32'h000A0008);
      check("bp_rsp_valid", {31'h0, rsp_valid[0]}, 32'd1);
      check("bp_req_ready", {31'h0, req_ready[0]}, 32'd0);
      check("bp_busy", {31'h0, busy[0]}, 32'd1);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    check("bp_not_accepted_on_hs", {31'h0, busy[0]}, 32'd0);
    check("bp_rsp_valid_dropped", {31'h0, rsp_valid[0]}, 32'd0);
    step();
    req_valid[0] = 1'b0;
    check("bp_accept_next", {31'h0, busy[0]}, 32'd1);
    cyc = 1;
    while (!rsp_valid[0] && cyc < 20) begin
      step();
      cyc++;
    end
    check("bp2_latency", cyc, 3);
    check("bp2_rsp_data", rsp_data[0], 32'd21);
    $display("dut0 backpressure follow-up op=0 a=3 b=7 -> data=0x%08h", rsp_data[0]);
    step();

    // Reset while the second pass is being captured.
    req_valid[0] = 1'b1;
    req_op[0]    = 2'd1;
    req_a[0]     = 32'hFFFFFFFF;
    req_b[0]     = 32'hFFFFFFFF;
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    check("cap2_busy", {31'h0, busy[0]}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", {31'h0, busy[0]}, 32'd0);
    check("rst_mid_rsp_valid", {31'h0, rsp_valid[0]}, 32'd0);
    check("rst_mid_cell_en", {31'h0, cell_en[0]}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("rst_mid_no_rsp", {31'h0, rsp_valid[0]}, 32'd0);
      step();
    end
    $display("dut0 reset in CAP2 -> no response");
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
